uart_rx: RTL

Serial UART receiver, 8N1, LSB first, idle-high line. It consumes the serial stream produced by uart_tx (loopback / peer link) and delivers parallel bytes to the host logic through a valid/ack holding register. Bit timing comes from an oversampling enable generated by the shared clock divider, at OVERSAMPLE × baud rate. The block detects false start bits, stop-bit framing errors and receive overruns.

---
 rtl/uart_rx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- 8N1 serial receiver, LSB first, idle-high line.
//
// Samples the line on an oversampling enable (OVERSAMPLE pulses per bit),
// aligns to the middle of the start bit, then samples each data bit and the
// stop bit one full bit period apart. Received bytes are handed to the host
// through a valid/ack holding register.
//
// Ports:
//   clk           system clock
//   reset         synchronous, active-high reset
//   sample_clk_en one-clk enable pulse at OVERSAMPLE x baud
//   rx_in         asynchronous serial line, idle high
//   data_ack      host consumed data_out; clears data_valid and overrun
//   data_out      last received byte, stable while data_valid is high
//   data_valid    byte available, held until data_ack
//   frame_error   one-clk pulse when the stop bit is sampled low
//   overrun       sticky; a byte completed while data_valid was still high
//   rx_busy       high whenever the receiver is not idle
// -----------------------------------------------------------------------------
module uart_rx #(
   parameter int OVERSAMPLE  = 16,
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       sample_clk_en,
   input  logic       rx_in,
   input  logic       data_ack,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_error,
   output logic       overrun,
   output logic       rx_busy
);

   localparam int            TW        = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA      = 3'd2,
      STOP      = 3'd3,
      WAIT_HIGH = 3'd4
   } state_t;

   state_t                 state;
   logic [SYNC_STAGES-1:0] sync;
   logic                   rx_s;
   logic [TW-1:0]          tick_cnt;
   logic [2:0]             bit_idx;
   logic [7:0]             shift;
   logic                   good_stop;

   // NOTE: the synchronizer resets to the idle level (1) so leaving reset
   // can never look like a falling start edge.
   always_ff @(posedge clk) begin
      if (reset) sync <= '1;
      else       sync <= {sync[SYNC_STAGES-2:0], rx_in};
   end

   assign rx_s = sync[SYNC_STAGES-1];

   // Stop bit sampled high this cycle: a byte is ready to commit.
   assign good_stop = (state == STOP) && sample_clk_en &&
                      (tick_cnt == TICK_LAST) && rx_s;

   assign rx_busy = (state != IDLE);

   // NOTE: all state here is sequential, so every assignment is non-blocking;
   // later assignments in the block override earlier ones for the same edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         tick_cnt    <= '0;
         bit_idx     <= '0;
         shift       <= '0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         frame_error <= 1'b0;
         overrun     <= 1'b0;
      end else begin
         frame_error <= 1'b0;

         if (data_ack && data_valid) begin
            data_valid <= 1'b0;
            overrun    <= 1'b0;
         end

         // A same-cycle ack frees the holding register for the new byte.
         if (good_stop) begin
            if (!data_valid || data_ack) begin
               data_out   <= shift;
               data_valid <= 1'b1;
            end else begin
               overrun <= 1'b1;
            end
         end

         case (state)
            IDLE: begin
               if (sample_clk_en && !rx_s) begin
                  state    <= START;
                  tick_cnt <= '0;
               end
            end
            START: begin
               if (sample_clk_en) begin
                  if (tick_cnt == TICK_MID) begin
                     tick_cnt <= '0;
                     bit_idx  <= '0;
                     // Line back high at mid start bit: glitch, drop it.
                     state    <= rx_s ? IDLE : DATA;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            DATA: begin
               if (sample_clk_en) begin
                  if (tick_cnt == TICK_LAST) begin
                     shift[bit_idx] <= rx_s;
                     tick_cnt       <= '0;
                     if (bit_idx == 3'd7) state   <= STOP;
                     else                 bit_idx <= bit_idx + 3'd1;
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            STOP: begin
               if (sample_clk_en) begin
                  if (tick_cnt == TICK_LAST) begin
                     tick_cnt <= '0;
                     if (rx_s) begin
                        state <= IDLE;
                     end else begin
                        frame_error <= 1'b1;
                        state       <= WAIT_HIGH;
                     end
                  end else begin
                     tick_cnt <= tick_cnt + 1'b1;
                  end
               end
            end
            // Hold off until the line is released so a break is not
            // mistaken for a stream of start bits.
            WAIT_HIGH: begin
               if (sample_clk_en && rx_s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
